fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline controller for the MIPS datapath's two 32-bit 3:1 ALU operand muxes: sel 00 = register file, 01 = EX/MEM result, 10 = MEM/WB writeback value.
- Computes forwarding selects in ID and registers them so they arrive aligned with the instruction entering EX.
- Detects load-use and branch-in-ID hazards and sequences stalls and bubbles.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 16, stall counter width

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  reset, asynchronous, active-low
- ID_Rs, ID_Rt  input  REG_W  source registers of the instruction in ID
- ID_UsesRs, ID_UsesRt  input  1  source actually read by the ID instruction
- ID_IsBranch  input  1  ID instruction is a branch compared in ID
- EX_Rd  input  REG_W  destination of the instruction in EX
- EX_RegWrite, EX_MemRead  input  1  EX instruction writes a register / is a load
- MEM_Rd  input  REG_W  destination of the instruction in MEM
- MEM_RegWrite, MEM_MemRead  input  1  MEM instruction writes a register / is a load
- Flush  input  1  taken branch/jump; kill the ID instruction
- FwdA_Sel, FwdB_Sel  output  2  registered selects for the EX operand A/B muxes
- PC_Write  output  1  0 = hold PC
- IFID_Write  output  1  0 = hold IF/ID register
- Bubble  output  1  1 = load a NOP into ID/EX
- StallCount  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (Rst_n=0, async): FwdA_Sel=FwdB_Sel=00, StallCnt=0, StallCount=0, PC_Write=1, IFID_Write=1, Bubble=0.
- Match definition: match(X, src) = X_RegWrite & (X_Rd != 0) & (X_Rd == src) & Uses(src). Register $0 never matches.
- Forward select for source s, computed from ID-stage inputs:
  - EX match -> 01, because the producer will be in MEM next cycle.
  - Else MEM match -> 10, because the producer will be in WB next cycle.
  - Else 00. WB-stage producers are covered by the write-first register file.
  - EX has priority over MEM on a double match.
- Hazard terms (combinational, current cycle):
  - LU: EX_MemRead & match(EX, Rs or Rt). Needs 1 stall.
  - BR1: ID_IsBranch & match(EX, Rs or Rt) & !EX_MemRead. Needs 1 stall.
  - BR2: ID_IsBranch & EX_MemRead & match(EX). Needs 2 stalls.
  - BRM: ID_IsBranch & MEM_MemRead & match(MEM). Needs 1 stall.
- Stall sequencer, 2-bit StallCnt:
  - Stall = (StallCnt != 0) | LU | BR1 | BR2 | BRM.
  - StallCnt is 0 and BR2 is true -> StallCnt <= 1 (one remaining after this cycle).
  - StallCnt != 0 -> StallCnt <= StallCnt - 1.
  - Flush -> StallCnt <= 0.
- Stall outputs are combinational: PC_Write = IFID_Write = !Stall & !... i.e. both equal !Stall when Flush=0.
- Bubble = Stall | Flush.
- Flush with simultaneous Stall: Flush wins. PC_Write=1 and IFID_Write=1 (PC takes the target; IF/ID is cleared by the flush logic), Bubble=1, StallCnt cleared.
- Select registers (posedge Clk):
  - Bubble=1 -> FwdA_Sel/FwdB_Sel <= 00, since the NOP must not forward.
  - Otherwise they load the computed selects. Latency is exactly 1 cycle from ID to EX.
- Sel value 11 is never driven.
- StallCount increments on each posedge with Stall=1 & Flush=0 and saturates at 2^CNT_W-1. It is cleared only by reset.
- Reset asserted mid-stall: everything returns to reset values immediately. The first cycle after deassertion evaluates hazards fresh.

Test Plan:
- EX: add $3 writing; ID: sub reading Rs=$3 -> no stall; next cycle FwdA_Sel=01, FwdB_Sel=00.
- EX writes $4 and MEM writes $4; ID Rt=$4 -> FwdB_Sel=01 (EX priority). Repeat with EX_Rd=$0 and MEM_Rd=$4 -> FwdB_Sel=10.
- Load-use: EX lw $5 (MemRead=1); ID Rs=$5 -> 1 cycle with PC_Write=0, IFID_Write=0, Bubble=1, FwdA_Sel=00 next cycle.
  - Then the inputs advance (MEM lw $5) -> no stall, FwdA_Sel=10.
  - StallCount=1.
- Branch on load: EX lw $6, ID beq reads $6 -> exactly 2 stall cycles (StallCnt 1->0), then PC_Write=1; StallCount +2.
- Flush during a BR2 stall (cycle 1) -> Bubble=1, PC_Write=1, StallCnt=0, no second stall cycle, StallCount +0 that cycle.
- Drive Rst_n low mid-stall between clock edges -> outputs go to reset values without a clock edge. StallCount reaching 0xFFFF stays at 0xFFFF on further stalls.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard/stall controller for a 5-stage MIPS pipeline.
// Selects are computed in ID and registered so they line up with the instruction entering EX.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_IsBranch,
    input  logic [REG_W-1:0] EX_Rd,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] MEM_Rd,
    input  logic             MEM_RegWrite,
    input  logic             MEM_MemRead,
    input  logic             Flush,
    output logic [1:0]       FwdA_Sel,
    output logic [1:0]       FwdB_Sel,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             Bubble,
    output logic [CNT_W-1:0] StallCount
);

    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [1:0]       r_stall_cnt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_ex_a, w_ex_b, w_mem_a, w_mem_b;
    logic w_ex_any, w_mem_any;
    logic w_lu, w_br1, w_br2, w_brm;
    logic w_stall, w_bubble;
    logic [1:0] w_sel_a, w_sel_b;

    // $0 is hard-wired zero, so it never counts as a producer.
    assign w_ex_a  = EX_RegWrite  & (EX_Rd  != '0) & (EX_Rd  == ID_Rs) & ID_UsesRs;
    assign w_ex_b  = EX_RegWrite  & (EX_Rd  != '0) & (EX_Rd  == ID_Rt) & ID_UsesRt;
    assign w_mem_a = MEM_RegWrite & (MEM_Rd != '0) & (MEM_Rd == ID_Rs) & ID_UsesRs;
    assign w_mem_b = MEM_RegWrite & (MEM_Rd != '0) & (MEM_Rd == ID_Rt) & ID_UsesRt;

    assign w_ex_any  = w_ex_a | w_ex_b;
    assign w_mem_any = w_mem_a | w_mem_b;

    assign w_lu  = EX_MemRead & w_ex_any;
    assign w_br1 = ID_IsBranch & w_ex_any & ~EX_MemRead;
    assign w_br2 = ID_IsBranch & EX_MemRead & w_ex_any;
    assign w_brm = ID_IsBranch & MEM_MemRead & w_mem_any;

    assign w_sel_a = w_ex_a ? 2'b01 : (w_mem_a ? 2'b10 : 2'b00);
    assign w_sel_b = w_ex_b ? 2'b01 : (w_mem_b ? 2'b10 : 2'b00);

    // Gated by reset so the handshake outputs read as idle while reset is held.
    assign w_stall  = Rst_n & ((r_stall_cnt != '0) | w_lu | w_br1 | w_br2 | w_brm);
    assign w_bubble = w_stall | (Rst_n & Flush);

    assign PC_Write   = ~w_stall | Flush;
    assign IFID_Write = ~w_stall | Flush;
    assign Bubble     = w_bubble;
    assign FwdA_Sel   = r_fwd_a;
    assign FwdB_Sel   = r_fwd_b;
    assign StallCount = r_stall_count;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_fwd_a       <= '0;
            r_fwd_b       <= '0;
            r_stall_cnt   <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_bubble) begin
                r_fwd_a <= '0;
                r_fwd_b <= '0;
            end else begin
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
            end

            if (Flush)
                r_stall_cnt <= '0;
            else if (r_stall_cnt != '0)
                r_stall_cnt <= r_stall_cnt - 2'd1;
            else if (w_br2)
                r_stall_cnt <= 2'd1;
            else
                r_stall_cnt <= '0;

            if (w_stall && !Flush && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a "stall cycles owed" reference model.
module tb_fwd_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 10;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic [REG_W-1:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
    logic             ID_UsesRs, ID_UsesRt, ID_IsBranch;
    logic             EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead, Flush;
    logic [1:0]       FwdA_Sel, FwdB_Sel;
    logic             PC_Write, IFID_Write, Bubble;
    logic [CNT_W-1:0] StallCount;

    int n_checks = 0;
    int n_errors = 0;

    fwd_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch),
        .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
        .Flush(Flush),
        .FwdA_Sel(FwdA_Sel), .FwdB_Sel(FwdB_Sel),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .Bubble(Bubble),
        .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_sel(input logic [REG_W-1:0] src, input logic uses);
        if (!uses || src == 0) return 2'b00;
        if (EX_RegWrite && EX_Rd == src) return 2'b01;   // nearest producer wins
        if (MEM_RegWrite && MEM_Rd == src) return 2'b10;
        return 2'b00;
    endfunction

    int         m_owed;   // further forced stall cycles still owed after this one
    int         m_cnt;
    logic [1:0] m_sel_a, m_sel_b;

    int         e_need;
    logic       e_stall, e_bubble, e_pcw;
    logic [1:0] e_sa, e_sb;

    always_comb begin
        logic ex_prod, mem_prod;
        e_sa     = ref_sel(ID_Rs, ID_UsesRs);
        e_sb     = ref_sel(ID_Rt, ID_UsesRt);
        ex_prod  = (e_sa == 2'b01) || (e_sb == 2'b01);
        mem_prod = (ref_sel(ID_Rs, ID_UsesRs & !(EX_RegWrite && EX_Rd == ID_Rs)) == 2'b10) ||
                   (ref_sel(ID_Rt, ID_UsesRt & !(EX_RegWrite && EX_Rd == ID_Rt)) == 2'b10);
        e_need = 0;
        if (ex_prod && EX_MemRead) e_need = ID_IsBranch ? 2 : 1;
        else if (ex_prod && ID_IsBranch) e_need = 1;
        if (ID_IsBranch && MEM_MemRead && mem_prod && e_need < 1) e_need = 1;
        e_stall  = (Rst_n === 1'b1) && (m_owed > 0 || e_need > 0);
        e_bubble = e_stall || ((Rst_n === 1'b1) && Flush);
        e_pcw    = !e_stall || Flush;
    end

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_owed  <= 0;
            m_cnt   <= 0;
            m_sel_a <= 2'b00;
            m_sel_b <= 2'b00;
        end else begin
            m_sel_a <= e_bubble ? 2'b00 : e_sa;
            m_sel_b <= e_bubble ? 2'b00 : e_sb;
            if (Flush) m_owed <= 0;
            else if (m_owed > 0) m_owed <= m_owed - 1;
            else m_owed <= (e_need > 0) ? e_need - 1 : 0;
            if (e_stall && !Flush && m_cnt < MAXC) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge Clk) begin
        chk("model_FwdA", {30'd0, FwdA_Sel}, {30'd0, m_sel_a});
        chk("model_FwdB", {30'd0, FwdB_Sel}, {30'd0, m_sel_b});
        chk("model_PC_Write", {31'd0, PC_Write}, {31'd0, e_pcw});
        chk("model_IFID_Write", {31'd0, IFID_Write}, {31'd0, e_pcw});
        chk("model_Bubble", {31'd0, Bubble}, {31'd0, e_bubble});
        chk("model_StallCount", 32'(StallCount), 32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 0; ID_UsesRt = 0; ID_IsBranch = 0;
        EX_Rd = '0; EX_RegWrite = 0; EX_MemRead = 0;
        MEM_Rd = '0; MEM_RegWrite = 0; MEM_MemRead = 0; Flush = 0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] s0;
        Rst_n = 1'b0;
        idle();
        #3;
        chk("rst_FwdA", 32'(FwdA_Sel), 32'd0);
        chk("rst_PC_Write", 32'(PC_Write), 32'd1);
        chk("rst_Bubble", 32'(Bubble), 32'd0);
        chk("rst_StallCount", 32'(StallCount), 32'd0);
        next_cycle();
        Rst_n = 1'b1;

        // add $3 in EX, sub reading $3 in ID
        next_cycle();
        EX_Rd = 3; EX_RegWrite = 1; ID_Rs = 3; ID_UsesRs = 1; ID_Rt = 7; ID_UsesRt = 1;
        @(negedge Clk);
        chk("fwd_ex_nostall", 32'(PC_Write), 32'd1);
        next_cycle(); idle();
        @(negedge Clk);
        chk("fwd_ex_A", 32'(FwdA_Sel), 32'd1);
        chk("fwd_ex_B", 32'(FwdB_Sel), 32'd0);

        // double match: EX priority, then EX_Rd=$0 falls through to MEM
        next_cycle();
        EX_Rd = 4; EX_RegWrite = 1; MEM_Rd = 4; MEM_RegWrite = 1; ID_Rt = 4; ID_UsesRt = 1;
        next_cycle();
        EX_Rd = 0;
        @(negedge Clk);
        chk("fwd_prio_B", 32'(FwdB_Sel), 32'd1);
        next_cycle(); idle();
        @(negedge Clk);
        chk("fwd_mem_B", 32'(FwdB_Sel), 32'd2);

        // load-use
        next_cycle();
        s0 = StallCount;
        EX_Rd = 5; EX_RegWrite = 1; EX_MemRead = 1; ID_Rs = 5; ID_UsesRs = 1;
        @(negedge Clk);
        chk("lu_PC_Write", 32'(PC_Write), 32'd0);
        chk("lu_IFID_Write", 32'(IFID_Write), 32'd0);
        chk("lu_Bubble", 32'(Bubble), 32'd1);
        next_cycle();
        EX_Rd = 0; EX_RegWrite = 0; EX_MemRead = 0; MEM_Rd = 5; MEM_RegWrite = 1; MEM_MemRead = 1;
        @(negedge Clk);
        chk("lu_FwdA_bubble", 32'(FwdA_Sel), 32'd0);
        chk("lu_release", 32'(PC_Write), 32'd1);
        chk("lu_StallCount", 32'(StallCount), 32'(s0) + 1);
        next_cycle(); idle();
        @(negedge Clk);
        chk("lu_FwdA_mem", 32'(FwdA_Sel), 32'd2);

        // branch on load: two stall cycles
        next_cycle();
        s0 = StallCount;
        EX_Rd = 6; EX_RegWrite = 1; EX_MemRead = 1; ID_Rs = 6; ID_UsesRs = 1; ID_IsBranch = 1;
        @(negedge Clk);
        chk("br2_stall1", 32'(PC_Write), 32'd0);
        next_cycle();
        EX_Rd = 0; EX_RegWrite = 0; EX_MemRead = 0;
        @(negedge Clk);
        chk("br2_stall2", 32'(PC_Write), 32'd0);
        next_cycle();
        MEM_Rd = 0; MEM_RegWrite = 0; MEM_MemRead = 0;
        @(negedge Clk);
        chk("br2_release", 32'(PC_Write), 32'd1);
        chk("br2_StallCount", 32'(StallCount), 32'(s0) + 2);

        // flush during first BR2 stall cycle
        next_cycle(); idle();
        s0 = StallCount;
        EX_Rd = 6; EX_RegWrite = 1; EX_MemRead = 1; ID_Rs = 6; ID_UsesRs = 1; ID_IsBranch = 1; Flush = 1;
        @(negedge Clk);
        chk("flush_Bubble", 32'(Bubble), 32'd1);
        chk("flush_PC_Write", 32'(PC_Write), 32'd1);
        chk("flush_IFID_Write", 32'(IFID_Write), 32'd1);
        next_cycle(); idle();
        @(negedge Clk);
        chk("flush_no_2nd", 32'(PC_Write), 32'd1);
        chk("flush_Bubble_off", 32'(Bubble), 32'd0);
        chk("flush_StallCount", 32'(StallCount), 32'(s0));

        // async reset mid-stall
        next_cycle();
        EX_Rd = 6; EX_RegWrite = 1; EX_MemRead = 1; ID_Rs = 6; ID_UsesRs = 1; ID_IsBranch = 1;
        @(negedge Clk);
        chk("arst_pre", 32'(PC_Write), 32'd0);
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_PC_Write", 32'(PC_Write), 32'd1);
        chk("arst_Bubble", 32'(Bubble), 32'd0);
        chk("arst_StallCount", 32'(StallCount), 32'd0);
        chk("arst_FwdA", 32'(FwdA_Sel), 32'd0);
        idle();
        next_cycle();
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("arst_fresh", 32'(PC_Write), 32'd1);

        // saturation of the stall counter under a held load-use
        next_cycle();
        EX_Rd = 9; EX_RegWrite = 1; EX_MemRead = 1; ID_Rt = 9; ID_UsesRt = 1;
        repeat (MAXC + 8) next_cycle();
        @(negedge Clk);
        chk("sat_StallCount", 32'(StallCount), 32'(MAXC));
        next_cycle(); idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            Rst_n        = ($urandom_range(0, 299) != 0);
            ID_Rs        = REG_W'($urandom_range(0, 7));
            ID_Rt        = REG_W'($urandom_range(0, 7));
            ID_UsesRs    = ($urandom_range(0, 3) != 0);
            ID_UsesRt    = ($urandom_range(0, 1) != 0);
            ID_IsBranch  = ($urandom_range(0, 3) == 0);
            EX_Rd        = REG_W'($urandom_range(0, 7));
            EX_RegWrite  = ($urandom_range(0, 3) != 0);
            EX_MemRead   = ($urandom_range(0, 2) == 0);
            MEM_Rd       = REG_W'($urandom_range(0, 7));
            MEM_RegWrite = ($urandom_range(0, 3) != 0);
            MEM_MemRead  = ($urandom_range(0, 2) == 0);
            Flush        = ($urandom_range(0, 9) == 0);
        end
        next_cycle();
        Rst_n = 1'b1;
        idle();
        @(negedge Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
